lab3_task1_tester: RTL and testbench

- Self-checking stimulus and response block for the lab 3 task 1 logic unit (inputs a/b/c, outputs x/y).
- Drives all 8 input combinations onto the unit and samples its x/y outputs.
- Compares each sample against golden values and reports pass/fail, error count and the first failing vector.
- Sits on the board top beside the unit under test: a/b/c out to the unit, x/y back in, results to LEDs.

---
 rtl/lab3_task1_tester.sv | 146 ++++++++++++++
 tb/tb_lab3_task1_tester.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_task1_tester.sv
// Stimulus/response tester for the lab 3 task 1 unit: walks {a,b,c} through 0..7 and checks x/y.
// Define LAB3_TESTER_LOOP_EN for continuous self-test, with results accumulating until reset.
module lab3_task1_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             x_in,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  // state  | meaning
  // IDLE   | waiting for start; results of the last run held
  // APPLY  | drive vector idx onto a/b/c, load settle timer
  // SETTLE | wait SETTLE_CYCLES for the unit outputs to settle
  // CHECK  | compare x_in/y_in with golden values, advance idx
  // DONE   | one-cycle done pulse, pass/fail reported
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // The terminal count is zero, so the timer loads one less than the wait length.
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] idx_q;
  logic [3:0] settle_q;

  logic exp_x;
  logic exp_y;
  logic mismatch;
  logic settle_tc;
  logic last_vec;
  logic any_err;

  assign exp_x     = ~c ^ (a | b);
  assign exp_y     = (~(a & b) ^ (a | b)) & (a | b);
  assign mismatch  = (x_in != exp_x) || (y_in != exp_y);
  assign settle_tc = (settle_q == 4'd0);
  assign last_vec  = (idx_q == 3'd7);
  // fail_valid tracks "any error so far" even once err_count has saturated.
  assign any_err   = mismatch || fail_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_APPLY;
      S_APPLY:  state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: if (settle_tc) state_d = S_CHECK;
      S_CHECK:  state_d = last_vec ? S_DONE : S_APPLY;
`ifdef LAB3_TESTER_LOOP_EN
      S_DONE:   state_d = S_APPLY;
`else
      S_DONE:   state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      idx_q      <= 3'd0;
      settle_q   <= 4'd0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q      <= 3'd0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
          end
        end
        S_APPLY: begin
          {a, b, c} <= idx_q;
          settle_q  <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (!settle_tc) settle_q <= settle_q - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= idx_q;
            end
          end
          // pass is settled on the way into DONE so it is valid alongside the done pulse.
          if (last_vec) begin
            pass <= !any_err;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
`ifdef LAB3_TESTER_LOOP_EN
        S_DONE: begin
          idx_q <= 3'd0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_task1_tester.sv
// Scoreboard bench for lab3_task1_tester: three tester instances, each fed by a table-driven unit model.
module tb_lab3_task1_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;
  int   fault = 0;
  int   sel = 0;

  logic [7:0] x_tab = 8'hA9;
  logic [7:0] y_tab = 8'hC0;

  logic a_m, b_m, c_m, x_m, y_m, busy_m, done_m, pass_m, fv_m;
  logic [3:0] err_m;
  logic [2:0] fvec_m;
  logic a_s, b_s, c_s, x_s, y_s, busy_s, done_s, pass_s, fv_s;
  logic [1:0] err_s;
  logic [2:0] fvec_s;
  logic a_f, b_f, c_f, x_f, y_f, busy_f, done_f, pass_f, fv_f;
  logic [3:0] err_f;
  logic [2:0] fvec_f;

  logic [2:0] o_vec, o_fvec;
  logic [3:0] o_err;
  logic o_busy, o_done, o_pass, o_fv;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit pass;
    int err;
    bit fv;
    int fvec;
    int lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  lab3_task1_tester #(.SETTLE_CYCLES(2), .ERR_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_m), .b(b_m), .c(c_m),
    .x_in(x_m), .y_in(y_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(err_m), .fail_valid(fv_m), .fail_vec(fvec_m));

  lab3_task1_tester #(.SETTLE_CYCLES(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_s), .b(b_s), .c(c_s),
    .x_in(x_s), .y_in(y_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_valid(fv_s), .fail_vec(fvec_s));

  lab3_task1_tester #(.SETTLE_CYCLES(0), .ERR_W(4)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_f), .b(b_f), .c(c_f),
    .x_in(x_f), .y_in(y_f), .busy(busy_f), .done(done_f), .pass(pass_f),
    .err_count(err_f), .fail_valid(fv_f), .fail_vec(fvec_f));

  // Unit under test model: fault 0 = correct, 1 = y stuck at 0, 2 = x inverted.
  always_comb begin
    x_m = x_tab[{a_m, b_m, c_m}] ^ (fault == 2);
    y_m = y_tab[{a_m, b_m, c_m}] & (fault != 1);
    x_s = x_tab[{a_s, b_s, c_s}] ^ (fault == 2);
    y_s = y_tab[{a_s, b_s, c_s}] & (fault != 1);
    x_f = x_tab[{a_f, b_f, c_f}] ^ (fault == 2);
    y_f = y_tab[{a_f, b_f, c_f}] & (fault != 1);
  end

  always_comb begin
    o_vec  = {a_m, b_m, c_m};
    o_busy = busy_m;
    o_done = done_m;
    o_pass = pass_m;
    o_err  = err_m;
    o_fv   = fv_m;
    o_fvec = fvec_m;
    if (sel == 1) begin
      o_vec  = {a_s, b_s, c_s};
      o_busy = busy_s;
      o_done = done_s;
      o_pass = pass_s;
      o_err  = {2'b00, err_s};
      o_fv   = fv_s;
      o_fvec = fvec_s;
    end else if (sel == 2) begin
      o_vec  = {a_f, b_f, c_f};
      o_busy = busy_f;
      o_done = done_f;
      o_pass = pass_f;
      o_err  = err_f;
      o_fv   = fv_f;
      o_fvec = fvec_f;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int f, input int errw, input int settle);
    exp_t e;
    int   cnt = 0;
    int   mx  = (1 << errw) - 1;
    bit   bad;
    e.fv   = 1'b0;
    e.fvec = 0;
    for (int v = 0; v < 8; v++) begin
      bad = (f == 2) || ((f == 1) && y_tab[v]);
      if (bad) begin
        if (cnt < mx) cnt++;
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fvec = v;
        end
      end
    end
    e.err  = cnt;
    e.pass = (cnt == 0);
    e.lat  = 8 * (2 + settle);
    return e;
  endfunction

  // Returns at the negedge just after start was accepted (k = 0 of the run).
  task automatic launch(input int s, input int f, input int errw, input int settle);
    sel   = s;
    fault = f;
    exp_q.push_back(predict(f, errw, settle));
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  task automatic track(input int settle, input bit mid_pulse, input bit hold);
    int   p   = 2 + settle;
    int   k   = 0;
    bit   got = 1'b0;
    exp_t e;
    while (k < 200) begin
      if (k == 0) chk("busy_on", o_busy, 1);
      if (k >= 1 && ((k - 1) % p) == 0 && k < 1 + 8 * p) chk("vec_step", o_vec, (k - 1) / p);
      if (mid_pulse && k == 10) start_v[sel] = 1'b1;
      if (mid_pulse && k == 11) start_v[sel] = 1'b0;
      if (hold && k == 20) start_v[sel] = 1'b1;
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    chk("done_seen", got, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("latency", k, e.lat);
    chk("pass", o_pass, e.pass);
    chk("err_count", o_err, e.err);
    chk("fail_valid", o_fv, e.fv);
    chk("fail_vec", o_fvec, e.fvec);
    @(negedge clk);
    chk("done_pulse", o_done, 0);
    chk("busy_off", o_busy, 0);
    chk("hold_vec", o_vec, 7);
    chk("pass_hold", o_pass, e.pass);
  endtask

  initial begin
    int seen;
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    sel = 0;
    chk("rst_vec", o_vec, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_err", o_err, 0);
    chk("rst_fv", o_fv, 0);
    chk("rst_fvec", o_fvec, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(0, 0, 4, 2);
    track(2, 1'b0, 1'b0);

    launch(0, 1, 4, 2);
    track(2, 1'b0, 1'b0);

    launch(1, 2, 2, 2);
    track(2, 1'b0, 1'b0);

    launch(2, 0, 4, 0);
    track(0, 1'b0, 1'b0);

    // Abort a run during SETTLE of vector 4 with x inverted, so err_count is nonzero beforehand.
    sel   = 0;
    fault = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_vec", o_vec, 4);
    chk("pre_rst_err", o_err, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_vec", o_vec, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_err", o_err, 0);
    chk("arst_fv", o_fv, 0);
    chk("arst_fvec", o_fvec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    launch(0, 0, 4, 2);
    track(2, 1'b0, 1'b0);

    // Mid-run start pulse is ignored; start then held high restarts right after DONE.
    launch(0, 1, 4, 2);
    track(2, 1'b1, 1'b1);
    chk("idle_err_held", o_err, 2);
    fault = 0;
    exp_q.push_back(predict(0, 4, 2));
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("restart_err_clr", o_err, 0);
    chk("restart_pass_clr", o_pass, 0);
    track(2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
